// File: rtl/hazard_forward_unit.sv
// Pipeline hazard unit: EX-stage operand forwarding, load-use stall sequencing
// with flush abort, and saturating stall/forward performance counters.
module hazard_forward_unit #(
    parameter int ADDR_W     = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_mem_reg_write,
    input  logic [ADDR_W-1:0] ex_mem_write_reg_addr,
    input  logic              mem_wb_reg_write,
    input  logic [ADDR_W-1:0] mem_wb_write_reg_addr,
    input  logic [ADDR_W-1:0] id_ex_instr_rs,
    input  logic [ADDR_W-1:0] id_ex_instr_rt,
    input  logic              id_ex_mem_read,
    input  logic [ADDR_W-1:0] id_ex_write_reg_addr,
    input  logic [ADDR_W-1:0] if_id_instr_rs,
    input  logic [ADDR_W-1:0] if_id_instr_rt,
    input  logic              if_id_uses_rs,
    input  logic              if_id_uses_rt,
    input  logic              flush,
    input  logic              cnt_clear,
    output logic [1:0]        Forward_A,
    output logic [1:0]        Forward_B,
    output logic              stall,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  fwd_count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [2:0]        REM_RELOAD = 3'(LOAD_STALL - 1);

    state_t            state_r;
    logic [2:0]        rem_r;
    logic              hazard_s;
    logic              stall_s;
    logic              fwd_active_s;
    logic [1:0]        forward_a_s;
    logic [1:0]        forward_b_s;
    logic [CNT_W-1:0]  stall_count_r;
    logic [CNT_W-1:0]  fwd_count_r;

    // EX/MEM result is newer than MEM/WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(
        input logic              exm_we,
        input logic [ADDR_W-1:0] exm_addr,
        input logic              mwb_we,
        input logic [ADDR_W-1:0] mwb_addr,
        input logic [ADDR_W-1:0] src
    );
        logic [1:0] sel;
        if (exm_we && (exm_addr != ADDR_ZERO) && (exm_addr == src)) begin
            sel = 2'b10;
        end else if (mwb_we && (mwb_addr != ADDR_ZERO) && (mwb_addr == src)) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    // Operand forwarding selects for both ALU inputs.
    always_comb begin
        forward_a_s = fwd_sel(ex_mem_reg_write, ex_mem_write_reg_addr,
                              mem_wb_reg_write, mem_wb_write_reg_addr, id_ex_instr_rs);
        forward_b_s = fwd_sel(ex_mem_reg_write, ex_mem_write_reg_addr,
                              mem_wb_reg_write, mem_wb_write_reg_addr, id_ex_instr_rt);
        fwd_active_s = (forward_a_s != 2'b00) || (forward_b_s != 2'b00);
    end

    // Load-use detection plus stall decision; reset and flush both mask the stall.
    always_comb begin
        hazard_s = id_ex_mem_read && (id_ex_write_reg_addr != ADDR_ZERO) &&
                   ((if_id_uses_rs && (if_id_instr_rs == id_ex_write_reg_addr)) ||
                    (if_id_uses_rt && (if_id_instr_rt == id_ex_write_reg_addr)));
        stall_s = 1'b0;
        if (rst || flush) begin
            stall_s = 1'b0;
        end else if (state_r == HOLD) begin
            stall_s = 1'b1;
        end else begin
            stall_s = hazard_s;
        end
    end

    // Stall sequencer: the first stall cycle is spent in IDLE, the rest in HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            rem_r   <= 3'd0;
        end else if (flush) begin
            state_r <= IDLE;
            rem_r   <= 3'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hazard_s && (LOAD_STALL > 1)) begin
                        state_r <= HOLD;
                        rem_r   <= REM_RELOAD;
                    end else begin
                        state_r <= IDLE;
                        rem_r   <= 3'd0;
                    end
                end
                HOLD: begin
                    if (rem_r <= 3'd1) begin
                        state_r <= IDLE;
                        rem_r   <= 3'd0;
                    end else begin
                        state_r <= HOLD;
                        rem_r   <= rem_r - 3'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    rem_r   <= 3'd0;
                end
            endcase
        end
    end

    // Saturating performance counters; clear beats increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_r <= {CNT_W{1'b0}};
            fwd_count_r   <= {CNT_W{1'b0}};
        end else if (cnt_clear) begin
            stall_count_r <= {CNT_W{1'b0}};
            fwd_count_r   <= {CNT_W{1'b0}};
        end else begin
            if (stall_s && (stall_count_r != CNT_MAX)) begin
                stall_count_r <= stall_count_r + CNT_ONE;
            end
            if (fwd_active_s && (fwd_count_r != CNT_MAX)) begin
                fwd_count_r <= fwd_count_r + CNT_ONE;
            end
        end
    end

    assign Forward_A    = forward_a_s;
    assign Forward_B    = forward_b_s;
    assign stall        = stall_s;
    assign pc_write     = ~stall_s;
    assign if_id_write  = ~stall_s;
    assign id_ex_bubble = stall_s;
    assign stall_count  = stall_count_r;
    assign fwd_count    = fwd_count_r;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: three instances share stimulus (LOAD_STALL=1, LOAD_STALL=3,
// and LOAD_STALL=3 with 4-bit counters) and are checked against hand-computed values.
`timescale 1ns/1ps
module tb_hazard_forward_unit;

    logic       clk;
    logic       rst;
    logic       ex_mem_reg_write, mem_wb_reg_write, id_ex_mem_read;
    logic [4:0] ex_mem_write_reg_addr, mem_wb_write_reg_addr;
    logic [4:0] id_ex_instr_rs, id_ex_instr_rt, id_ex_write_reg_addr;
    logic [4:0] if_id_instr_rs, if_id_instr_rt;
    logic       if_id_uses_rs, if_id_uses_rt, flush, cnt_clear;

    logic [1:0]  fa_a, fb_a, fa_b, fb_b, fa_c, fb_c;
    logic        stall_a, pcw_a, ifw_a, bub_a;
    logic        stall_b, pcw_b, ifw_b, bub_b;
    logic        stall_c, pcw_c, ifw_c, bub_c;
    logic [15:0] sc_a, fc_a, sc_b, fc_b;
    logic [3:0]  sc_c, fc_c;

    int checks = 0;
    int errors = 0;

    hazard_forward_unit #(.ADDR_W(5), .LOAD_STALL(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_write_reg_addr(ex_mem_write_reg_addr),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_write_reg_addr(mem_wb_write_reg_addr),
        .id_ex_instr_rs(id_ex_instr_rs), .id_ex_instr_rt(id_ex_instr_rt),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_write_reg_addr(id_ex_write_reg_addr),
        .if_id_instr_rs(if_id_instr_rs), .if_id_instr_rt(if_id_instr_rt),
        .if_id_uses_rs(if_id_uses_rs), .if_id_uses_rt(if_id_uses_rt),
        .flush(flush), .cnt_clear(cnt_clear),
        .Forward_A(fa_a), .Forward_B(fb_a), .stall(stall_a), .pc_write(pcw_a),
        .if_id_write(ifw_a), .id_ex_bubble(bub_a), .stall_count(sc_a), .fwd_count(fc_a)
    );

    hazard_forward_unit #(.ADDR_W(5), .LOAD_STALL(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_write_reg_addr(ex_mem_write_reg_addr),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_write_reg_addr(mem_wb_write_reg_addr),
        .id_ex_instr_rs(id_ex_instr_rs), .id_ex_instr_rt(id_ex_instr_rt),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_write_reg_addr(id_ex_write_reg_addr),
        .if_id_instr_rs(if_id_instr_rs), .if_id_instr_rt(if_id_instr_rt),
        .if_id_uses_rs(if_id_uses_rs), .if_id_uses_rt(if_id_uses_rt),
        .flush(flush), .cnt_clear(cnt_clear),
        .Forward_A(fa_b), .Forward_B(fb_b), .stall(stall_b), .pc_write(pcw_b),
        .if_id_write(ifw_b), .id_ex_bubble(bub_b), .stall_count(sc_b), .fwd_count(fc_b)
    );

    hazard_forward_unit #(.ADDR_W(5), .LOAD_STALL(3), .CNT_W(4)) dut_c (
        .clk(clk), .rst(rst),
        .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_write_reg_addr(ex_mem_write_reg_addr),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_write_reg_addr(mem_wb_write_reg_addr),
        .id_ex_instr_rs(id_ex_instr_rs), .id_ex_instr_rt(id_ex_instr_rt),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_write_reg_addr(id_ex_write_reg_addr),
        .if_id_instr_rs(if_id_instr_rs), .if_id_instr_rt(if_id_instr_rt),
        .if_id_uses_rs(if_id_uses_rs), .if_id_uses_rt(if_id_uses_rt),
        .flush(flush), .cnt_clear(cnt_clear),
        .Forward_A(fa_c), .Forward_B(fb_c), .stall(stall_c), .pc_write(pcw_c),
        .if_id_write(ifw_c), .id_ex_bubble(bub_c), .stall_count(sc_c), .fwd_count(fc_c)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_mem_reg_write = 1'b0; ex_mem_write_reg_addr = 5'd0;
        mem_wb_reg_write = 1'b0; mem_wb_write_reg_addr = 5'd0;
        id_ex_instr_rs = 5'd0; id_ex_instr_rt = 5'd0;
        id_ex_mem_read = 1'b0; id_ex_write_reg_addr = 5'd0;
        if_id_instr_rs = 5'd0; if_id_instr_rt = 5'd0;
        if_id_uses_rs = 1'b0; if_id_uses_rt = 1'b0;
        flush = 1'b0; cnt_clear = 1'b0;
    endtask

    // Return every instance to IDLE with zeroed counters.
    task automatic quiesce();
        idle_inputs();
        flush = 1'b1; cnt_clear = 1'b1;
        tick();
        flush = 1'b0; cnt_clear = 1'b0;
    endtask

    task automatic set_load_hazard(input logic [4:0] dest);
        id_ex_mem_read = 1'b1; id_ex_write_reg_addr = dest;
        if_id_instr_rs = dest; if_id_uses_rs = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #1;
        if (stall_a !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b exp 0", stall_a); end
        checks++;
        if ({pcw_b, ifw_b, bub_b} !== 3'b110) begin errors++; $display("FAIL reset_ctrl got %b exp 110", {pcw_b, ifw_b, bub_b}); end
        checks++;
        set_load_hazard(5'd6);
        ex_mem_reg_write = 1'b1; ex_mem_write_reg_addr = 5'd3; id_ex_instr_rs = 5'd3;
        #1;
        if ({stall_a, stall_b} !== 2'b00) begin errors++; $display("FAIL reset_hazard_masked got %b exp 00", {stall_a, stall_b}); end
        checks++;
        if (fa_b !== 2'b10) begin errors++; $display("FAIL reset_fwd_comb got %b exp 10", fa_b); end
        checks++;
        tick();
        if ({sc_a, fc_a, sc_b, fc_b} !== 64'd0) begin errors++; $display("FAIL reset_counts got %h exp 0", {sc_a, fc_a, sc_b, fc_b}); end
        checks++;
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_forwarding();
        quiesce();
        ex_mem_reg_write = 1'b1; ex_mem_write_reg_addr = 5'd3;
        mem_wb_reg_write = 1'b1; mem_wb_write_reg_addr = 5'd3;
        id_ex_instr_rs = 5'd3; id_ex_instr_rt = 5'd3;
        #1;
        if ({fa_a, fb_a} !== 4'b1010) begin errors++; $display("FAIL fwd_exmem_prio got %b exp 1010", {fa_a, fb_a}); end
        checks++;
        ex_mem_reg_write = 1'b0;
        #1;
        if ({fa_a, fb_a} !== 4'b0101) begin errors++; $display("FAIL fwd_memwb got %b exp 0101", {fa_a, fb_a}); end
        checks++;
        ex_mem_reg_write = 1'b1; ex_mem_write_reg_addr = 5'd0; mem_wb_write_reg_addr = 5'd0;
        id_ex_instr_rs = 5'd0; id_ex_instr_rt = 5'd0;
        #1;
        if ({fa_a, fb_a} !== 4'b0000) begin errors++; $display("FAIL fwd_zero_reg got %b exp 0000", {fa_a, fb_a}); end
        checks++;
        ex_mem_write_reg_addr = 5'd3; mem_wb_write_reg_addr = 5'd4;
        id_ex_instr_rs = 5'd3; id_ex_instr_rt = 5'd4;
        #1;
        if ({fa_b, fb_b} !== 4'b1001) begin errors++; $display("FAIL fwd_mixed got %b exp 1001", {fa_b, fb_b}); end
        checks++;
        tick();
        if (fc_a !== 16'd1) begin errors++; $display("FAIL fwd_count_one got %0d exp 1", fc_a); end
        checks++;
    endtask

    task automatic test_load_stall_1();
        quiesce();
        id_ex_mem_read = 1'b1; id_ex_write_reg_addr = 5'd5; if_id_instr_rs = 5'd5;
        #1;
        if ({stall_a, stall_b} !== 2'b00) begin errors++; $display("FAIL ls1_unused_rs got %b exp 00", {stall_a, stall_b}); end
        checks++;
        if_id_uses_rs = 1'b1;
        #1;
        if ({stall_a, pcw_a, ifw_a, bub_a} !== 4'b1001) begin errors++; $display("FAIL ls1_stall got %b exp 1001", {stall_a, pcw_a, ifw_a, bub_a}); end
        checks++;
        tick();
        id_ex_mem_read = 1'b0;
        #1;
        if ({stall_a, pcw_a} !== 2'b01) begin errors++; $display("FAIL ls1_release got %b exp 01", {stall_a, pcw_a}); end
        checks++;
        if (sc_a !== 16'd1) begin errors++; $display("FAIL ls1_count got %0d exp 1", sc_a); end
        checks++;
        quiesce();
        id_ex_mem_read = 1'b1; id_ex_write_reg_addr = 5'd0; if_id_uses_rs = 1'b1; if_id_instr_rs = 5'd0;
        #1;
        if (stall_a !== 1'b0) begin errors++; $display("FAIL ls1_dest_zero got %0b exp 0", stall_a); end
        checks++;
        id_ex_write_reg_addr = 5'd9; if_id_uses_rs = 1'b0; if_id_instr_rt = 5'd9; if_id_uses_rt = 1'b1;
        #1;
        if (stall_a !== 1'b1) begin errors++; $display("FAIL ls1_rt_path got %0b exp 1", stall_a); end
        checks++;
    endtask

    task automatic test_load_stall_3();
        logic [2:0] seen;
        quiesce();
        set_load_hazard(5'd7);
        #1;
        seen[0] = stall_b;
        tick();
        idle_inputs();
        #1;
        seen[1] = stall_b;
        tick();
        seen[2] = stall_b;
        if (seen !== 3'b111) begin errors++; $display("FAIL ls3_three_cycles got %b exp 111", seen); end
        checks++;
        tick();
        if (stall_b !== 1'b0) begin errors++; $display("FAIL ls3_end got %0b exp 0", stall_b); end
        checks++;
        if ({sc_b, sc_c} !== {16'd3, 4'd3}) begin errors++; $display("FAIL ls3_count got %0d/%0d exp 3/3", sc_b, sc_c); end
        checks++;
    endtask

    task automatic test_flush();
        quiesce();
        set_load_hazard(5'd8);
        tick();
        idle_inputs();
        flush = 1'b1;
        #1;
        if ({stall_b, pcw_b} !== 2'b01) begin errors++; $display("FAIL flush_same_cycle got %b exp 01", {stall_b, pcw_b}); end
        checks++;
        tick();
        flush = 1'b0;
        #1;
        if (stall_b !== 1'b0) begin errors++; $display("FAIL flush_idle got %0b exp 0", stall_b); end
        checks++;
        if (sc_b !== 16'd1) begin errors++; $display("FAIL flush_count got %0d exp 1", sc_b); end
        checks++;
        set_load_hazard(5'd8);
        flush = 1'b1;
        #1;
        if (stall_b !== 1'b0) begin errors++; $display("FAIL flush_over_hazard got %0b exp 0", stall_b); end
        checks++;
        tick();
        idle_inputs();
        #1;
        if ({stall_b, sc_b} !== {1'b0, 16'd1}) begin errors++; $display("FAIL flush_no_hold got %0b/%0d exp 0/1", stall_b, sc_b); end
        checks++;
    endtask

    task automatic test_reset_mid_hold();
        int n;
        quiesce();
        set_load_hazard(5'd10);
        tick();
        idle_inputs();
        #1;
        if (stall_b !== 1'b1) begin errors++; $display("FAIL rmh_in_hold got %0b exp 1", stall_b); end
        checks++;
        #2;
        rst = 1'b1;
        #1;
        if ({stall_b, sc_b} !== {1'b0, 16'd0}) begin errors++; $display("FAIL rmh_async got %0b/%0d exp 0/0", stall_b, sc_b); end
        checks++;
        #2;
        rst = 1'b0;
        tick();
        if (stall_b !== 1'b0) begin errors++; $display("FAIL rmh_after_release got %0b exp 0", stall_b); end
        checks++;
        set_load_hazard(5'd11);
        n = 0;
        #1;
        if (stall_b) n++;
        tick();
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            #1;
            if (stall_b) n++;
            tick();
        end
        if (n != 3) begin errors++; $display("FAIL rmh_full_stall got %0d exp 3", n); end
        checks++;
        if (sc_b !== 16'd3) begin errors++; $display("FAIL rmh_count got %0d exp 3", sc_b); end
        checks++;
    endtask

    task automatic test_saturation();
        quiesce();
        ex_mem_reg_write = 1'b1; ex_mem_write_reg_addr = 5'd3; id_ex_instr_rs = 5'd3;
        for (int i = 0; i < 20; i++) tick();
        if ({fc_c, fc_a} !== {4'd15, 16'd20}) begin errors++; $display("FAIL sat_fwd got %0d/%0d exp 15/20", fc_c, fc_a); end
        checks++;
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
        if (fc_c !== 4'd0) begin errors++; $display("FAIL sat_clear got %0d exp 0", fc_c); end
        checks++;
        tick();
        if (fc_c !== 4'd1) begin errors++; $display("FAIL sat_restart got %0d exp 1", fc_c); end
        checks++;
        quiesce();
        set_load_hazard(5'd12);
        for (int i = 0; i < 20; i++) tick();
        if ({sc_c, sc_b} !== {4'd15, 16'd20}) begin errors++; $display("FAIL sat_stall got %0d/%0d exp 15/20", sc_c, sc_b); end
        checks++;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_stall_1();
        test_load_stall_3();
        test_flush();
        test_reset_mid_hold();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter ADDR_W, default 5, SHALL set register-address width.
REQ-002 Parameter LOAD_STALL, default 1, legal 1..7, SHALL set stall cycles per load-use hazard.
REQ-003 Parameter CNT_W, default 16, SHALL set performance-counter width.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  SHALL be the reset: asynchronous, active-high.
REQ-006 ex_mem_reg_write  in  1; ex_mem_write_reg_addr  in  ADDR_W  SHALL give the EX/MEM destination and its write enable.
REQ-007 mem_wb_reg_write  in  1; mem_wb_write_reg_addr  in  ADDR_W  SHALL give the MEM/WB destination and its write enable.
REQ-008 id_ex_instr_rs, id_ex_instr_rt  in  ADDR_W  SHALL give the EX-stage source registers.
REQ-009 id_ex_mem_read  in  1; id_ex_write_reg_addr  in  ADDR_W  SHALL flag a load in ID/EX and its destination.
REQ-010 if_id_instr_rs, if_id_instr_rt  in  ADDR_W; if_id_uses_rs, if_id_uses_rt  in  1  SHALL give the ID-stage sources and their use flags.
REQ-011 flush  in  1  SHALL abort any stall (branch/jump redirect); cnt_clear  in  1  SHALL synchronously zero both counters.
REQ-012 Forward_A, Forward_B  out  2  SHALL select the ALU operand source: 00 register file, 10 EX/MEM, 01 MEM/WB.
REQ-013 stall  out  1; pc_write  out  1; if_id_write  out  1; id_ex_bubble  out  1  SHALL control the pipeline.
REQ-014 stall_count, fwd_count  out  CNT_W  SHALL be saturating performance counters.

Function
REQ-015 Forward_A SHALL be 10 when ex_mem_reg_write=1, ex_mem_write_reg_addr!=0 and ex_mem_write_reg_addr==id_ex_instr_rs.
REQ-016 Otherwise, Forward_A SHALL be 01 when mem_wb_reg_write=1, mem_wb_write_reg_addr!=0 and mem_wb_write_reg_addr==id_ex_instr_rs; otherwise it SHALL be 00.
REQ-017 Forward_B SHALL follow REQ-015/016 with id_ex_instr_rt; EX/MEM SHALL always have priority over MEM/WB, and the forward outputs SHALL be combinational with no latch.
REQ-018 A hazard SHALL exist when id_ex_mem_read=1, id_ex_write_reg_addr!=0, and it equals (if_id_instr_rs with if_id_uses_rs=1) or (if_id_instr_rt with if_id_uses_rt=1).
REQ-019 The FSM SHALL have exactly two states: IDLE and HOLD, with a 3-bit down-counter rem.
REQ-020 In IDLE with a hazard and flush=0, stall SHALL assert combinationally in that cycle.
  - If LOAD_STALL>1: next state SHALL be HOLD with rem=LOAD_STALL-1.
  - If LOAD_STALL=1: the FSM SHALL stay in IDLE.
REQ-021 In HOLD, stall SHALL be 1 and rem SHALL decrement each cycle; when rem==1 the next state SHALL be IDLE, giving exactly LOAD_STALL stall cycles in total.
REQ-022 In HOLD, new hazard detection SHALL be ignored; hazards SHALL be re-evaluated in IDLE.
REQ-023 flush=1 SHALL force stall=0 in the same cycle and next state IDLE with rem=0, from any state; flush SHALL take priority over a hazard.
REQ-024 pc_write and if_id_write SHALL equal ~stall, and id_ex_bubble SHALL equal stall.
REQ-025 stall_count SHALL increment in every cycle with stall=1, and fwd_count in every cycle where Forward_A!=00 or Forward_B!=00; both SHALL saturate at all-ones without wrapping.
REQ-026 cnt_clear=1 SHALL zero both counters on the next edge, overriding any increment in the same cycle.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, rem=0, stall_count=0 and fwd_count=0, independent of clk.
REQ-028 During rst=1, stall SHALL be 0, pc_write=1 and if_id_write=1, and id_ex_bubble=0; the forward outputs SHALL remain combinational.
REQ-029 A reset asserted mid-HOLD SHALL abandon the stall; after release, the FSM SHALL start in IDLE.

Verification
REQ-030 ex_mem(we=1,addr=3), mem_wb(we=1,addr=3), id_ex rs=3 rt=3 -> Forward_A=Forward_B=10; with ex_mem we=0 -> both 01; with all addr=0 -> both 00.
REQ-031 LOAD_STALL=1; id_ex_mem_read=1 with dest 5, if_id rs=5 uses_rs=1 -> stall=1 and pc_write=0 for exactly 1 cycle; with uses_rs=0 -> stall=0.
REQ-032 LOAD_STALL=3, same hazard held for one cycle -> stall=1 for exactly 3 consecutive cycles, then 0; stall_count=3.
REQ-033 LOAD_STALL=3; flush=1 in the second stall cycle -> stall=0 that cycle, FSM in IDLE, stall_count=1.
REQ-034 rst pulsed asynchronously mid-HOLD -> stall=0 and counters=0 before the next edge; the next hazard gives a full LOAD_STALL stall.
REQ-035 CNT_W=4, forwarding active for 20 cycles -> fwd_count=15 held; cnt_clear together with forwarding -> fwd_count=0.
